// File: rtl/mfp_ahb_simple_master.sv
// Single-outstanding AHB-Lite initiator issuing single-word transfers from a local command port.
// Latency 2 cycles accept->rsp_valid with zero wait states; cmd_ready is low while a transfer is in flight.
module mfp_ahb_simple_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [9:0] WAIT_MAX      = 10'h3FF;
    localparam logic [9:0] WAIT_LIMIT    = 10'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [9:0]  wait_inc;

    always_comb begin
        state_d       = state_q;
        htrans_d      = htrans_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_inc      = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 10'd1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_ADDR;
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = cmd_addr & 32'hFFFF_FFFC;
                    hwrite_d = cmd_write;
                    wdata_d  = cmd_wdata;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d    = ST_DATA;
                    htrans_d   = HTRANS_IDLE;
                    hwdata_d   = hwrite_q ? wdata_q : 32'h0;
                    wait_cnt_d = 10'd0;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = hwrite_q ? 32'h0 : HRDATA;
                    rsp_err_d     = HRESP;
                    rsp_timeout_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_inc;
                    // Abandon the transfer once the slave has stalled for the full budget.
                    if (wait_inc >= WAIT_LIMIT) begin
                        state_d       = ST_IDLE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = 32'h0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            htrans_q      <= HTRANS_IDLE;
            haddr_q       <= 32'h0;
            hwrite_q      <= 1'b0;
            hwdata_q      <= 32'h0;
            wdata_q       <= 32'h0;
            wait_cnt_q    <= 10'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            htrans_q      <= htrans_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hwdata_q      <= hwdata_d;
            wdata_q       <= wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HWRITE      = hwrite_q;
    assign HWDATA      = hwdata_q;
    assign HSIZE       = 3'b010;
    assign HBURST      = 3'b000;
    assign HPROT       = 4'b0011;
    assign HMASTLOCK   = 1'b0;

endmodule

// File: tb/tb_mfp_ahb_simple_master.sv
// Scoreboard bench: commands push expected bus phases and responses; monitors pop and compare.
module tb_mfp_ahb_simple_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    mfp_ahb_simple_master #(.TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          acc;
        int          lat;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } bus_exp_t;

    rsp_exp_t exp_rsp[$];
    bus_exp_t exp_bus[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave configuration for the transfer in flight
    int          cfg_aw = 0, cfg_dw = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(posedge HCLK) cyc++;

    // Reactive slave: drives HREADY/HRESP/HRDATA shortly after each edge.
    initial begin
        int acnt = 0, dcnt = 0;
        bit data_pend = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        forever begin
            @(posedge HCLK);
            #1;
            if (!HRESETn || rsp_valid) data_pend = 0;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
            if (HRESETn && HTRANS == 2'b10) begin
                if (acnt < cfg_aw) begin
                    HREADY = 1'b0;
                    acnt++;
                end else begin
                    acnt = 0; dcnt = 0; data_pend = 1;
                end
            end else if (data_pend) begin
                if (dcnt < cfg_dw) begin
                    HREADY = 1'b0;
                    HRESP  = cfg_err && (dcnt == cfg_dw - 1);
                    dcnt++;
                end else begin
                    HRESP  = cfg_err;
                    HRDATA = cfg_rdata;
                    data_pend = 0;
                end
            end
        end
    end

    // Bus monitor: address phases, data-phase HWDATA, no back-to-back NONSEQ.
    initial begin
        bit dnext = 0, prev_addr_done = 0;
        logic [31:0] exp_wd = 32'h0;
        bus_exp_t b;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dnext = 0; prev_addr_done = 0;
            end else begin
                if (dnext) begin
                    dnext = 0;
                    chk("data_htrans", {30'h0, HTRANS}, 32'h0);
                    chk("data_hwdata", HWDATA, exp_wd);
                end
                if (HTRANS == 2'b10) begin
                    chk("nonseq_not_back_to_back", {31'h0, prev_addr_done}, 32'h0);
                    if (exp_bus.size() == 0) begin
                        bad++; total++;
                        $display("FAIL unexpected_nonseq: got addr %h want none", HADDR);
                    end else begin
                        b = exp_bus[0];
                        chk("addr_haddr", HADDR, b.addr);
                        chk("addr_hwrite", {31'h0, HWRITE}, {31'h0, b.write});
                        if (HREADY) begin
                            void'(exp_bus.pop_front());
                            chk("addr_fixed", {HSIZE, HBURST, HPROT, HMASTLOCK},
                                {3'b010, 3'b000, 4'b0011, 1'b0});
                            exp_wd = b.wdata;
                            dnext = 1;
                        end
                    end
                end
                prev_addr_done = (HTRANS == 2'b10) && HREADY;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge HCLK);
            if (HRESETn && rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    bad++; total++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 want 0");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.tmo});
                    chk("rsp_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int aw, input int dw, input logic err, input logic [31:0] rd,
                         input logic [31:0] x_rdata, input logic x_err, input logic x_tmo,
                         input int lat, input bit keep);
        bit ok = 0;
        @(negedge HCLK);
        cfg_aw = aw; cfg_dw = dw; cfg_err = err; cfg_rdata = rd;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                exp_rsp.push_back('{x_rdata, x_err, x_tmo, cyc + 1, lat});
                exp_bus.push_back('{a & 32'hFFFF_FFFC, w, w ? d : 32'h0});
                ok = 1;
                break;
            end
            @(negedge HCLK);
        end
        if (!ok) begin
            bad++; total++;
            $display("FAIL accept_timeout: got cmd_ready=0 want 1");
        end
        @(posedge HCLK);
        #1;
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_addr  = 32'hDEAD_BEEF;
            cmd_wdata = 32'h5555_AAAA;
            cmd_write = ~w;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_bus.size() != 0) && n < 60) begin
            @(negedge HCLK);
            n++;
        end
        if (exp_rsp.size() != 0 || exp_bus.size() != 0) begin
            bad++; total++;
            $display("FAIL drain: got %0d pending want 0", exp_rsp.size() + exp_bus.size());
        end
        repeat (2) @(negedge HCLK);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
    endtask

    initial begin
        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        repeat (3) @(negedge HCLK);
        chk_reset_vals();
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk_reset_vals();

        // Zero-wait write; inputs scrambled after accept must not leak onto the bus
        issue(1'b1, 32'hBF80_0004, 32'h1234_5678, 0, 0, 1'b0, 32'h0,
              32'h0, 1'b0, 1'b0, 2, 0);
        drain();

        // Read with 3 data wait states, unaligned address
        issue(1'b0, 32'hBF80_000B, 32'h0, 0, 3, 1'b0, 32'hCAFE_F00D,
              32'hCAFE_F00D, 1'b0, 1'b0, 5, 0);
        drain();
        repeat (3) @(negedge HCLK);
        chk("rsp_rdata_hold", rsp_rdata, 32'hCAFE_F00D);

        // Two-cycle error response, then a normal read
        issue(1'b0, 32'h0000_0100, 32'h0, 0, 1, 1'b1, 32'h1111_2222,
              32'h1111_2222, 1'b1, 1'b0, 3, 0);
        drain();
        issue(1'b0, 32'h0000_0200, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D,
              32'h0BAD_F00D, 1'b0, 1'b0, 2, 0);
        drain();

        // Timeout after 4 wait cycles
        issue(1'b0, 32'h0000_0300, 32'h0, 0, 1000, 1'b0, 32'hFFFF_FFFF,
              32'h0, 1'b1, 1'b1, 5, 0);
        drain();
        chk("timeout_htrans_idle", {30'h0, HTRANS}, 32'h0);
        chk("timeout_err_hold", {31'h0, rsp_timeout}, 32'h1);

        // Address-phase stall of 2 cycles
        issue(1'b1, 32'h0000_0400, 32'hA5A5_0001, 2, 0, 1'b0, 32'h0,
              32'h0, 1'b0, 1'b0, 4, 0);
        drain();

        // cmd_valid held across two commands
        issue(1'b1, 32'h0000_0500, 32'h0000_0011, 0, 0, 1'b0, 32'h0,
              32'h0, 1'b0, 1'b0, 2, 1);
        issue(1'b1, 32'h0000_0504, 32'h0000_0022, 0, 0, 1'b0, 32'h0,
              32'h0, 1'b0, 1'b0, 2, 0);
        drain();

        // Reset in the data phase abandons the transfer with no response
        issue(1'b0, 32'h0000_0600, 32'h0, 0, 10, 1'b0, 32'h7777_7777,
              32'h7777_7777, 1'b0, 1'b0, 12, 0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b0;
        exp_rsp.delete();
        exp_bus.delete();
        @(negedge HCLK);
        chk_reset_vals();
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);
        chk_reset_vals();

        // Recovery after reset
        issue(1'b1, 32'h0000_0700, 32'hFEED_BEEF, 0, 0, 1'b0, 32'h0,
              32'h0, 1'b0, 1'b0, 2, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
